// File: rtl/miriscv_apb_bridge.sv
// Core data-port bridge: address bit 31 steers a request to the single-cycle RAM
// or to one of two APB slaves (UART / timer), with a bounded ACCESS phase.
module miriscv_apb_bridge #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,
  output logic              data_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic [1:0]        psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [XLEN-1:0]   paddr_o,
  output logic [XLEN-1:0]   pwdata_o,
  output logic [XLEN/8-1:0] pstrb_o,
  input  logic [2*XLEN-1:0] prdata_i,
  input  logic [1:0]        pready_i,
  input  logic [1:0]        pslverr_i
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RAM_RSP = 2'd1;
  localparam logic [1:0] SETUP   = 2'd2;
  localparam logic [1:0] ACCESS  = 2'd3;

  logic [1:0]      state_q;
  logic            slot_q;
  logic [7:0]      cnt_q;
  logic            rsp_q;
  logic            err_q;
  logic [XLEN-1:0] rdata_q;

  logic            ram_req;
  logic            apb_req;
  logic            sel_ready;
  logic            sel_err;
  logic [XLEN-1:0] sel_rdata;
  logic            timeout_hit;

  assign data_gnt_o  = (state_q == IDLE) & data_req_i;
  assign ram_req     = data_gnt_o & ~data_addr_i[31];
  assign apb_req     = data_gnt_o &  data_addr_i[31];

  // RAM side is a straight pass-through; its data comes back one cycle later.
  assign mem_req_o   = ram_req;
  assign mem_we_o    = data_we_i;
  assign mem_be_o    = data_be_i;
  assign mem_addr_o  = data_addr_i;
  assign mem_wdata_o = data_wdata_i;

  assign sel_ready   = slot_q ? pready_i[1]  : pready_i[0];
  assign sel_err     = slot_q ? pslverr_i[1] : pslverr_i[0];
  assign sel_rdata   = slot_q ? prdata_i[2*XLEN-1:XLEN] : prdata_i[XLEN-1:0];
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  // Select/enable derive from state so an async reset drops them at once.
  assign psel_o    = (state_q == SETUP || state_q == ACCESS) ? (slot_q ? 2'b10 : 2'b01) : 2'b00;
  assign penable_o = (state_q == ACCESS);

  assign data_rvalid_o = (state_q == RAM_RSP) | rsp_q;
  assign data_rdata_o  = (state_q == RAM_RSP) ? mem_rdata_i : rdata_q;
  assign data_err_o    = err_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= IDLE;
      slot_q   <= 1'b0;
      cnt_q    <= '0;
      rsp_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      pwrite_o <= 1'b0;
      paddr_o  <= '0;
      pwdata_o <= '0;
      pstrb_o  <= '0;
    end else begin
      // APB response lives exactly one cycle; rdata_q stays 0 otherwise.
      rsp_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (ram_req) begin
            state_q <= RAM_RSP;
          end else if (apb_req) begin
            state_q  <= SETUP;
            slot_q   <= data_addr_i[12];
            paddr_o  <= data_addr_i;
            pwdata_o <= data_wdata_i;
            pwrite_o <= data_we_i;
            pstrb_o  <= data_be_i;
          end
        end
        RAM_RSP: state_q <= IDLE;
        SETUP: begin
          state_q <= ACCESS;
          cnt_q   <= '0;
        end
        ACCESS: begin
          if (sel_ready) begin
            state_q <= IDLE;
            rsp_q   <= 1'b1;
            err_q   <= sel_err;
            rdata_q <= pwrite_o ? '0 : sel_rdata;
          end else if (timeout_hit) begin
            state_q <= IDLE;
            rsp_q   <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= XLEN'(32'hDEAD_BEEF);
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_apb_bridge.sv
// Directed bench for miriscv_apb_bridge: vector table plus hand sequences for
// back-to-back requests and reset during ACCESS.
module tb_miriscv_apb_bridge;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [1:0]  psel_o;
  logic        penable_o, pwrite_o;
  logic [31:0] paddr_o, pwdata_o;
  logic [3:0]  pstrb_o;
  logic [63:0] prdata_i;
  logic [1:0]  pready_i, pslverr_i;

  int tests  = 0;
  int errors = 0;
  int mon_err = 0;
  int cur_wait = -1;
  int acc_cnt = 0;

  always #5 clk_i = ~clk_i;

  miriscv_apb_bridge #(.XLEN(32), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  // APB slave model: ready in the cur_wait-th ACCESS cycle; 0 = tied high, -1 = never.
  always @(negedge clk_i) begin
    if (penable_o) acc_cnt = acc_cnt + 1;
    else           acc_cnt = 0;
    if (cur_wait == 0)                          pready_i = 2'b11;
    else if (cur_wait > 0 && penable_o && acc_cnt >= cur_wait) pready_i = psel_o;
    else                                        pready_i = 2'b00;
  end

  always @(negedge clk_i) begin
    if (arstn_i) begin
      if (psel_o == 2'b11) mon_err = mon_err + 1;
      if (!data_rvalid_o && data_rdata_o != 32'h0) mon_err = mon_err + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          wait_c;
    logic [31:0] prd0, prd1, mrd;
    logic [1:0]  slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_acc;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input vec_t v, input string nm);
    int lat, acc;
    logic stab_bad;
    logic [1:0] exp_sel;
    exp_sel  = v.addr[12] ? 2'b10 : 2'b01;
    stab_bad = 1'b0;
    acc      = 0;
    @(posedge clk_i); #1;
    data_addr_i = v.addr; data_we_i = v.we; data_wdata_i = v.wdata; data_be_i = v.be;
    cur_wait = v.wait_c; prdata_i = {v.prd1, v.prd0}; mem_rdata_i = v.mrd;
    pslverr_i = v.slverr; data_req_i = 1'b1;
    @(negedge clk_i);
    check({nm, " gnt/mem_req"}, {62'd0, data_gnt_o, mem_req_o}, {62'd0, 1'b1, ~v.addr[31]});
    for (lat = 1; lat <= 40; lat++) begin
      @(posedge clk_i); #1;
      data_req_i = 1'b0;
      @(negedge clk_i);
      if (penable_o) begin
        acc = acc + 1;
        if (psel_o != exp_sel || paddr_o != v.addr || pwrite_o != v.we ||
            (v.we && (pwdata_o != v.wdata || pstrb_o != v.be)))
          stab_bad = 1'b1;
      end
      if (data_rvalid_o) break;
    end
    check({nm, " latency"}, 64'(lat), 64'(v.exp_lat));
    check({nm, " rdata/err"}, {31'd0, data_err_o, data_rdata_o}, {31'd0, v.exp_err, v.exp_rdata});
    if (v.addr[31]) begin
      check({nm, " access cycles"}, 64'(acc), 64'(v.exp_acc));
      check({nm, " apb stable"}, 64'(stab_bad), 64'd0);
    end
    @(negedge clk_i);
    check({nm, " rvalid pulse"}, 64'(data_rvalid_o), 64'd0);
    cur_wait = -1; pslverr_i = 2'b00;
  endtask

  initial begin
    int bad, seen;
    vecs[0] = '{32'h0000_0100, 1'b0, 32'h0, 4'hF, 0, 32'h0, 32'h0, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0, 1, 0};
    vecs[1] = '{32'h0000_0040, 1'b1, 32'h77, 4'h3, 0, 32'h0, 32'h0, 32'hA5A5_A5A5, 2'b00, 32'hA5A5_A5A5, 1'b0, 1, 0};
    vecs[2] = '{32'h8000_0004, 1'b1, 32'h41, 4'h1, 0, 32'h9, 32'h9, 32'h0, 2'b00, 32'h0, 1'b0, 3, 1};
    vecs[3] = '{32'h8000_1000, 1'b0, 32'h0, 4'hF, 5, 32'h1111, 32'hCAFE, 32'h0, 2'b00, 32'hCAFE, 1'b0, 7, 5};
    vecs[4] = '{32'h8000_0008, 1'b0, 32'h0, 4'hF, -1, 32'h1, 32'h2, 32'h0, 2'b00, 32'hDEAD_BEEF, 1'b1, 10, 8};
    vecs[5] = '{32'h8000_1004, 1'b1, 32'h9, 4'hF, 2, 32'h3, 32'h4, 32'h0, 2'b10, 32'h0, 1'b1, 4, 2};
    vecs[6] = '{32'h8000_0010, 1'b0, 32'h0, 4'hF, 1, 32'h55AA, 32'hBAD, 32'h0, 2'b10, 32'h55AA, 1'b0, 3, 1};

    arstn_i = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
    data_addr_i = 32'h0; data_wdata_i = 32'h0; mem_rdata_i = 32'h0;
    prdata_i = 64'h0; pslverr_i = 2'b00;
    repeat (3) @(negedge clk_i);
    check("reset outputs",
          {29'd0, data_rvalid_o, data_err_o, psel_o, penable_o, pwrite_o},
          64'd0);
    check("reset rdata/paddr", {data_rdata_o, paddr_o}, 64'd0);
    check("reset pwdata/pstrb", {28'd0, pstrb_o, pwdata_o}, 64'd0);
    arstn_i = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: next (RAM) request held while the timer write is in flight.
    @(posedge clk_i); #1;
    data_addr_i = 32'h8000_1008; data_we_i = 1'b1; data_wdata_i = 32'h5; data_be_i = 4'hF;
    cur_wait = 2; pslverr_i = 2'b10; data_req_i = 1'b1;
    @(negedge clk_i);
    check("b2b first gnt", 64'(data_gnt_o), 64'd1);
    @(posedge clk_i); #1;
    data_addr_i = 32'h0000_0200; data_we_i = 1'b0; mem_rdata_i = 32'hBEEF_0001;
    bad = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (data_rvalid_o) begin seen = 1; break; end
      if (data_gnt_o) bad = bad + 1;
    end
    check("b2b no gnt while busy", 64'(bad), 64'd0);
    check("b2b apb rsp", {62'd0, 1'(seen), data_err_o}, {62'd0, 2'b11});
    check("b2b gnt in rsp cycle", {63'd0, data_gnt_o}, 64'd1);
    @(posedge clk_i); #1;
    data_req_i = 1'b0; cur_wait = -1; pslverr_i = 2'b00;
    @(negedge clk_i);
    check("b2b ram rsp", {31'd0, data_rvalid_o, data_rdata_o}, {31'd0, 1'b1, 32'hBEEF_0001});

    // Reset pulse during ACCESS.
    @(posedge clk_i); #1;
    data_addr_i = 32'h8000_0000; data_we_i = 1'b0; cur_wait = -1; data_req_i = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    data_req_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (penable_o) begin seen = 1; break; end
    end
    check("rst reached access", 64'(seen), 64'd1);
    arstn_i = 1'b0;
    #1;
    check("rst drops apb", {61'd0, psel_o, penable_o}, 64'd0);
    check("rst no rvalid", 64'(data_rvalid_o), 64'd0);
    repeat (2) @(negedge clk_i);
    arstn_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (data_rvalid_o || psel_o != 2'b00) seen = 1;
    end
    check("rst abandoned transfer", 64'(seen), 64'd0);
    run_vec(vecs[0], "post-reset ram");
    run_vec(vecs[6], "post-reset uart");

    check("monitor psel/rdata", 64'(mon_err), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/miriscv_apb_bridge.md
MIRISCV_APB_BRIDGE -- requirements
Module: miriscv_apb_bridge

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, max ACCESS cycles before forced error (1..255).
REQ-003 SHALL have ports clk_i in 1 (single clock) and arstn_i in 1; reset is asynchronous, active-low.
REQ-004 SHALL have core-side ports: data_req_i in 1; data_we_i in 1; data_be_i in XLEN/8; data_addr_i in XLEN; data_wdata_i in XLEN.
REQ-005 SHALL have core-side ports: data_gnt_o out 1 (request accepted this cycle); data_rvalid_o out 1; data_rdata_o out XLEN; data_err_o out 1 (qualified by rvalid).
REQ-006 SHALL have RAM ports: mem_req_o out 1; mem_we_o out 1; mem_be_o out XLEN/8; mem_addr_o out XLEN; mem_wdata_o out XLEN; mem_rdata_i in XLEN (valid one cycle after mem_req_o).
REQ-007 SHALL have APB ports: psel_o out 2 (bit0 UART, bit1 timer); penable_o out 1; pwrite_o out 1; paddr_o out XLEN; pwdata_o out XLEN; pstrb_o out XLEN/8; prdata_i in 2*XLEN (slot n at [n*XLEN+:XLEN]); pready_i in 2; pslverr_i in 2.

Function
REQ-008 Decode SHALL be: addr[31]=0 -> RAM; addr[31]=1 & addr[12]=0 -> UART (slot 0); addr[31]=1 & addr[12]=1 -> timer (slot 1).
REQ-009 FSM SHALL have states IDLE, RAM_RSP, SETUP, ACCESS; only one transaction outstanding.
REQ-010 data_gnt_o SHALL equal data_req_i while in IDLE, 0 otherwise (combinational).
REQ-011 IDLE + req to RAM: mem_req_o=1 with core signals passed through same cycle; next state RAM_RSP.
REQ-012 RAM_RSP: data_rvalid_o=1, data_rdata_o=mem_rdata_i, data_err_o=0 for one cycle; then IDLE.
REQ-013 IDLE + req to APB: register addr, wdata, we, be, slot; next state SETUP.
REQ-014 SETUP: psel_o[slot]=1, penable_o=0, paddr/pwdata/pwrite/pstrb from registers; next ACCESS.
REQ-015 ACCESS: psel_o[slot]=1, penable_o=1; APB outputs SHALL hold stable until completion.
REQ-016 ACCESS completes when pready_i[slot]=1: next cycle data_rvalid_o=1, data_rdata_o=registered prdata (0 on writes), data_err_o=registered pslverr_i[slot]; state returns IDLE in that same response cycle.
REQ-017 ACCESS cycle counter SHALL start at 0 on ACCESS entry; if it reaches TIMEOUT without pready, transfer SHALL abort: psel/penable drop, response cycle with data_err_o=1, data_rdata_o=32'hDEAD_BEEF.
REQ-018 Unselected slot psel bit SHALL be 0 at all times; psel_o SHALL never be 2'b11.
REQ-019 data_rvalid_o SHALL be a single-cycle pulse per granted request; no rvalid without prior gnt.
REQ-020 Requests arriving during a non-IDLE state SHALL be ignored (no gnt); core holds req.
REQ-021 RAM latency gnt->rvalid SHALL be 1 cycle; APB zero-wait latency gnt->rvalid SHALL be 3 cycles.
REQ-022 data_rdata_o SHALL be 0 whenever data_rvalid_o=0.

Reset
REQ-023 On arstn_i=0 (async): state IDLE, counter 0, all registered outputs 0: data_rvalid_o, data_err_o, data_rdata_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o.
REQ-024 Reset mid-transfer SHALL abandon it without emitting rvalid; first gnt possible the first cycle after deassertion.

Verification
REQ-025 RAM read addr 0x0000_0100, mem_rdata_i=0x1234_5678 -> gnt cycle 0, rvalid cycle 1 with rdata 0x1234_5678, err 0.
REQ-026 UART write addr 0x8000_0004, wdata 0x41, pready tied 1 -> psel_o=01 SETUP cycle 1, penable cycle 2, rvalid cycle 3, err 0.
REQ-027 Timer read addr 0x8000_1000, pready after 5 ACCESS cycles, prdata=0xCAFE -> APB signals stable 5 cycles, rvalid rdata 0xCAFE.
REQ-028 UART read, pready never asserted, TIMEOUT=8 -> abort after 8 ACCESS cycles, rvalid with err 1, rdata 0xDEADBEEF.
REQ-029 Timer write with pslverr_i[1]=1 at pready -> rvalid err 1; back-to-back req held during transfer -> no gnt until IDLE.
REQ-030 arstn_i pulsed low during ACCESS -> psel_o=0, penable_o=0 immediately, no rvalid; next request served normally.
